// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency word reads and buffers them in a
// DEPTH-entry prefetch FIFO. Define FETCH_PERF_CNT_EN to add bubble/flush performance counters.
module fetch_unit #(
    parameter int unsigned             ADDR_W   = 32,
    parameter int unsigned             DATA_W   = 32,
    parameter logic [ADDR_W-1:0]       RESET_PC = '0,
    parameter int unsigned             PC_STEP  = 1,
    parameter int unsigned             DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,output logic [31:0]      perf_bubble_cnt
    ,output logic [31:0]      perf_flush_cnt
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              epoch_q, epoch_d;
    logic              inflight_q;
    logic              tag_epoch_q;
    logic [ADDR_W-1:0] tag_pc_q;

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic              pop;
    logic              issue;
    logic              resp_valid;
    logic              push;
    logic [CW-1:0]     occ;

    assign instr_valid = !rst && (count_q != '0);
    assign instr_data  = data_mem_q[rd_ptr_q];
    assign instr_pc    = pc_mem_q[rd_ptr_q];
    assign pop         = instr_valid && instr_ready;

    // Occupancy after this cycle's pop, counting the word already on its way back from memory.
    assign occ   = count_q + CW'(inflight_q) - CW'(pop);
    assign issue = !rst && !halt && !branch_valid && (occ < CW'(DEPTH));

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    assign resp_valid = inflight_q && (tag_epoch_q == epoch_q);
    assign push       = resp_valid && !branch_valid;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        epoch_d  = epoch_q;
        if (branch_valid) begin
            pc_d     = branch_target;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            epoch_d  = !epoch_q;
        end else begin
            if (issue) begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            epoch_q     <= 1'b0;
            inflight_q  <= 1'b0;
            tag_epoch_q <= 1'b0;
            tag_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            epoch_q    <= epoch_d;
            inflight_q <= issue;
            if (issue) begin
                tag_epoch_q <= epoch_q;
                tag_pc_q    <= pc_q;
            end
        end
    end

    // Storage needs no reset: count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= tag_pc_q;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == CW'(DEPTH)) && !pop));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_q, bubble_d;
    logic [31:0] flush_q, flush_d;
    logic        discard;

    assign discard = branch_valid && (((count_q - CW'(pop)) != '0) || resp_valid);

    always_comb begin
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (!instr_valid && instr_ready && !halt && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_d = bubble_q + 32'd1;
        end
        if (discard && (flush_q != 32'hFFFF_FFFF)) begin
            flush_d = flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign perf_bubble_cnt = bubble_q;
    assign perf_flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns 0xA0 + address one cycle after each request.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        halt;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_pass;
    int n_total;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,.perf_bubble_cnt (perf_bubble_cnt)
        ,.perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hA0 + imem_addr;
    end

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b1;
        branch_valid = 1'b0;
        halt = 1'b0;
        instr_ready = ready;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_total++; if (perf_bubble_cnt !== 32'h0) $display("FAIL reset_bubble got %0d want 0", perf_bubble_cnt); else n_pass++;
        n_total++; if (perf_flush_cnt !== 32'h0) $display("FAIL reset_flush got %0d want 0", perf_flush_cnt); else n_pass++;
`endif
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            n_total++; if (imem_req !== 1'b1) $display("FAIL stream_req k=%0d got %b want 1", k, imem_req); else n_pass++;
            n_total++; if (imem_addr !== 32'(k)) $display("FAIL stream_addr k=%0d got %h want %h", k, imem_addr, 32'(k)); else n_pass++;
            n_total++; if (instr_valid !== (k >= 2)) $display("FAIL stream_valid k=%0d got %b want %b", k, instr_valid, (k >= 2)); else n_pass++;
            if (k >= 2) begin
                n_total++; if (instr_data !== 32'hA0 + 32'(k - 2)) $display("FAIL stream_data k=%0d got %h want %h", k, instr_data, 32'hA0 + 32'(k - 2)); else n_pass++;
                n_total++; if (instr_pc !== 32'(k - 2)) $display("FAIL stream_pc k=%0d got %h want %h", k, instr_pc, 32'(k - 2)); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            n_total++; if (imem_req !== (k < 2)) $display("FAIL bp_req k=%0d got %b want %b", k, imem_req, (k < 2)); else n_pass++;
            n_total++; if (instr_valid !== (k >= 2)) $display("FAIL bp_valid k=%0d got %b want %b", k, instr_valid, (k >= 2)); else n_pass++;
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            instr_ready = 1'b1;
            #1;
            n_total++; if (instr_valid !== 1'b1) $display("FAIL bp_drain_valid j=%0d got %b want 1", j, instr_valid); else n_pass++;
            n_total++; if (instr_data !== 32'hA0 + 32'(j)) $display("FAIL bp_drain_data j=%0d got %h want %h", j, instr_data, 32'hA0 + 32'(j)); else n_pass++;
            n_total++; if (instr_pc !== 32'(j)) $display("FAIL bp_drain_pc j=%0d got %h want %h", j, instr_pc, 32'(j)); else n_pass++;
            n_total++; if (imem_addr !== 32'(j + 2) || imem_req !== 1'b1) $display("FAIL bp_drain_issue j=%0d got req=%b addr=%h want req=1 addr=%h", j, imem_req, imem_addr, 32'(j + 2)); else n_pass++;
        end
    endtask

    task automatic test_branch();
        do_reset(1'b0);
        #1;
        repeat (3) @(negedge clk);
        branch_valid = 1'b1;
        branch_target = 32'h10;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL br_cycle_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (instr_valid !== 1'b1) $display("FAIL br_full_valid got %b want 1", instr_valid); else n_pass++;
        for (int m = 0; m < 5; m++) begin
            @(negedge clk);
            branch_valid = 1'b0;
            instr_ready = 1'b1;
            #1;
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 + 32'(m)) $display("FAIL br_issue m=%0d got req=%b addr=%h want req=1 addr=%h", m, imem_req, imem_addr, 32'h10 + 32'(m)); else n_pass++;
            n_total++; if (instr_valid !== (m >= 2)) $display("FAIL br_valid m=%0d got %b want %b", m, instr_valid, (m >= 2)); else n_pass++;
            if (m >= 2) begin
                n_total++; if (instr_pc !== 32'h10 + 32'(m - 2) || instr_data !== 32'hB0 + 32'(m - 2)) $display("FAIL br_head m=%0d got pc=%h data=%h want pc=%h data=%h", m, instr_pc, instr_data, 32'h10 + 32'(m - 2), 32'hB0 + 32'(m - 2)); else n_pass++;
            end
        end
        @(negedge clk);
        branch_valid = 1'b1;
        branch_target = 32'h40;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL br2_cycle_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h13 || instr_data !== 32'hB3) $display("FAIL br2_pop got v=%b pc=%h data=%h want v=1 pc=13 data=b3", instr_valid, instr_pc, instr_data); else n_pass++;
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            branch_valid = 1'b0;
            #1;
            if (m < 2) begin
                n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 + 32'(m)) $display("FAIL br2_issue m=%0d got req=%b addr=%h want req=1 addr=%h", m, imem_req, imem_addr, 32'h40 + 32'(m)); else n_pass++;
                n_total++; if (instr_valid !== 1'b0) $display("FAIL br2_stale m=%0d got valid=%b pc=%h want valid=0", m, instr_valid, instr_pc); else n_pass++;
            end else begin
                n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_data !== 32'hE0) $display("FAIL br2_first got v=%b pc=%h data=%h want v=1 pc=40 data=e0", instr_valid, instr_pc, instr_data); else n_pass++;
            end
        end
    endtask

    task automatic test_halt();
        logic exp_v;
        do_reset(1'b1);
        #1;
        repeat (4) @(negedge clk);
        halt = 1'b1;
        for (int k = 4; k < 8; k++) begin
            if (k != 4) @(negedge clk);
            #1;
            exp_v = (k < 6);
            n_total++; if (imem_req !== 1'b0) $display("FAIL halt_req k=%0d got %b want 0", k, imem_req); else n_pass++;
            n_total++; if (instr_valid !== exp_v) $display("FAIL halt_valid k=%0d got %b want %b", k, instr_valid, exp_v); else n_pass++;
            if (exp_v) begin
                n_total++; if (instr_pc !== 32'(k - 2)) $display("FAIL halt_drain_pc k=%0d got %h want %h", k, instr_pc, 32'(k - 2)); else n_pass++;
            end
        end
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            halt = 1'b0;
            #1;
            if (m < 2) begin
                n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 + m)) $display("FAIL halt_resume m=%0d got req=%b addr=%h want req=1 addr=%h", m, imem_req, imem_addr, 32'(4 + m)); else n_pass++;
            end else begin
                n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr_data !== 32'hA4) $display("FAIL halt_resume_head got v=%b pc=%h data=%h want v=1 pc=4 data=a4", instr_valid, instr_pc, instr_data); else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        branch_valid = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL wrap_br_req got %b want 0", imem_req); else n_pass++;
        @(negedge clk);
        branch_valid = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFF) $display("FAIL wrap_addr0 got req=%b addr=%h want req=1 addr=ffffffff", imem_req, imem_addr); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_addr1 got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFF || instr_data !== 32'h9F) $display("FAIL wrap_head0 got v=%b pc=%h data=%h want v=1 pc=ffffffff data=9f", instr_valid, instr_pc, instr_data); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== 32'hA0) $display("FAIL wrap_head1 got v=%b pc=%h data=%h want v=1 pc=0 data=a0", instr_valid, instr_pc, instr_data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        #1;
        n_total++; if (instr_valid !== 1'b1 || imem_req !== 1'b1) $display("FAIL rmid_pre got v=%b req=%b want 1 1", instr_valid, imem_req); else n_pass++;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", instr_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rmid_req got %b want 0", imem_req); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_total++; if (perf_bubble_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) $display("FAIL rmid_perf got bubble=%0d flush=%0d want 0 0", perf_bubble_cnt, perf_flush_cnt); else n_pass++;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            if (m != 0) @(negedge clk);
            #1;
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'(m)) $display("FAIL rmid_restart m=%0d got req=%b addr=%h want req=1 addr=%h", m, imem_req, imem_addr, 32'(m)); else n_pass++;
            n_total++; if (instr_valid !== (m >= 2)) $display("FAIL rmid_valid_after m=%0d got %b want %b", m, instr_valid, (m >= 2)); else n_pass++;
        end
        n_total++; if (instr_pc !== 32'h0 || instr_data !== 32'hA0) $display("FAIL rmid_head got pc=%h data=%h want pc=0 data=a0", instr_pc, instr_data); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        branch_valid = 1'b0;
        branch_target = '0;
        halt = 1'b0;
        instr_ready = 1'b0;
        imem_rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
